// File: rtl/alu_exec_pkg.sv
// Shared definitions for the ALU execution unit: widths, opcode enum, ROB tag constants.
// Every issue-side block uses the same opcode encoding.
package alu_exec_pkg;

    localparam int ALU_DATA_W = 32;
    localparam int ALU_ROB_W  = 4;
    localparam int ALU_OP_W   = 6;

    typedef logic [ALU_DATA_W-1:0] DATA_TYPE;
    typedef logic [ALU_ROB_W-1:0]  ROB_POS_TYPE;

    typedef enum logic [ALU_OP_W-1:0] {
        OPENUM_NOP   = 6'd0,
        OPENUM_LUI   = 6'd1,
        OPENUM_AUIPC = 6'd2,
        OPENUM_JAL   = 6'd3,
        OPENUM_JALR  = 6'd4,
        OPENUM_BEQ   = 6'd5,
        OPENUM_BNE   = 6'd6,
        OPENUM_BLT   = 6'd7,
        OPENUM_BGE   = 6'd8,
        OPENUM_BLTU  = 6'd9,
        OPENUM_BGEU  = 6'd10,
        OPENUM_LB    = 6'd11,
        OPENUM_LH    = 6'd12,
        OPENUM_LW    = 6'd13,
        OPENUM_LBU   = 6'd14,
        OPENUM_LHU   = 6'd15,
        OPENUM_SB    = 6'd16,
        OPENUM_SH    = 6'd17,
        OPENUM_SW    = 6'd18,
        OPENUM_ADDI  = 6'd19,
        OPENUM_SLTI  = 6'd20,
        OPENUM_SLTIU = 6'd21,
        OPENUM_XORI  = 6'd22,
        OPENUM_ORI   = 6'd23,
        OPENUM_ANDI  = 6'd24,
        OPENUM_SLLI  = 6'd25,
        OPENUM_SRLI  = 6'd26,
        OPENUM_SRAI  = 6'd27,
        OPENUM_ADD   = 6'd28,
        OPENUM_SUB   = 6'd29,
        OPENUM_SLL   = 6'd30,
        OPENUM_SLT   = 6'd31,
        OPENUM_SLTU  = 6'd32,
        OPENUM_XOR   = 6'd33,
        OPENUM_SRL   = 6'd34,
        OPENUM_SRA   = 6'd35,
        OPENUM_OR    = 6'd36,
        OPENUM_AND   = 6'd37
    } OPENUM_TYPE;

    localparam ROB_POS_TYPE ZERO_ROB = '0;
    localparam logic        TRUE     = 1'b1;
    localparam logic        FALSE    = 1'b0;

    // Immediate-form ALU ops take their second operand from imm instead of rs2.
    function automatic logic is_imm_form(input logic [ALU_OP_W-1:0] op);
        logic w_imm;
        w_imm = FALSE;
        case (op)
            OPENUM_ADDI, OPENUM_SLTI, OPENUM_SLTIU, OPENUM_XORI, OPENUM_ORI,
            OPENUM_ANDI, OPENUM_SLLI, OPENUM_SRLI, OPENUM_SRAI: w_imm = TRUE;
            default: w_imm = FALSE;
        endcase
        return w_imm;
    endfunction

    function automatic logic is_branch(input logic [ALU_OP_W-1:0] op);
        logic w_br;
        w_br = FALSE;
        case (op)
            OPENUM_BEQ, OPENUM_BNE, OPENUM_BLT, OPENUM_BGE,
            OPENUM_BLTU, OPENUM_BGEU: w_br = TRUE;
            default: w_br = FALSE;
        endcase
        return w_br;
    endfunction

endpackage

// File: rtl/alu_exec_branch_cmp.sv
// Branch condition evaluation: decides whether a conditional branch is taken.
// Purely combinational; non-branch ops report not-taken.
module alu_branch_cmp
    import alu_exec_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int OP_W   = ALU_OP_W
) (
    input  logic [OP_W-1:0]   i_op,
    input  logic [DATA_W-1:0] i_v1,
    input  logic [DATA_W-1:0] i_v2,
    output logic              o_taken
);

    logic w_eq;
    logic w_lt;
    logic w_ltu;

    assign w_eq  = (i_v1 == i_v2);
    assign w_lt  = ($signed(i_v1) < $signed(i_v2));
    assign w_ltu = (i_v1 < i_v2);

    always_comb begin
        o_taken = FALSE;
        case (i_op)
            OPENUM_BEQ:  o_taken = w_eq;
            OPENUM_BNE:  o_taken = !w_eq;
            OPENUM_BLT:  o_taken = w_lt;
            OPENUM_BGE:  o_taken = !w_lt;
            OPENUM_BLTU: o_taken = w_ltu;
            OPENUM_BGEU: o_taken = !w_ltu;
            default:     o_taken = FALSE;
        endcase
    end

endmodule

// File: rtl/alu_exec.sv
// Integer/branch/jump execution unit fed by the reservation station.
// One op per cycle, result registered onto the ALU CDB one cycle later.
module alu_exec
    import alu_exec_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int ROB_W  = ALU_ROB_W,
    parameter int OP_W   = ALU_OP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [OP_W-1:0]   in_rs_op,
    input  logic [DATA_W-1:0] in_rs_value1,
    input  logic [DATA_W-1:0] in_rs_value2,
    input  logic [DATA_W-1:0] in_rs_imm,
    input  logic [ROB_W-1:0]  in_rs_rob_pos,
    input  logic [DATA_W-1:0] in_rs_pc,
    input  logic              in_rob_xbp,
    output logic [ROB_W-1:0]  out_cdb_pos,
    output logic [DATA_W-1:0] out_cdb_value,
    output logic              out_cdb_jump,
    output logic [DATA_W-1:0] out_cdb_target
);

    logic [ROB_W-1:0]  r_cdb_pos;
    logic [DATA_W-1:0] r_cdb_value;
    logic              r_cdb_jump;
    logic [DATA_W-1:0] r_cdb_target;

    logic [DATA_W-1:0] w_op2;
    logic [4:0]        w_shamt;
    logic [DATA_W-1:0] w_pc_plus4;
    logic [DATA_W-1:0] w_pc_plus_imm;
    logic [DATA_W-1:0] w_jalr_sum;
    logic              w_taken;
    logic              w_known;
    logic              w_issue;
    logic [DATA_W-1:0] w_value;
    logic              w_jump;
    logic [DATA_W-1:0] w_target;

    assign w_op2         = is_imm_form(in_rs_op) ? in_rs_imm : in_rs_value2;
    assign w_shamt       = w_op2[4:0];
    assign w_pc_plus4    = in_rs_pc + DATA_W'(4);
    assign w_pc_plus_imm = in_rs_pc + in_rs_imm;
    assign w_jalr_sum    = in_rs_value1 + in_rs_imm;

    alu_branch_cmp #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W)
    ) u_branch_cmp (
        .i_op    (in_rs_op),
        .i_v1    (in_rs_value1),
        .i_v2    (in_rs_value2),
        .o_taken (w_taken)
    );

    // Ops outside the ALU's repertoire (NOP, loads, stores, undefined) leave w_known low.
    always_comb begin
        w_known  = TRUE;
        w_value  = '0;
        w_jump   = FALSE;
        w_target = w_pc_plus4;
        case (in_rs_op)
            OPENUM_ADD, OPENUM_ADDI:   w_value = in_rs_value1 + w_op2;
            OPENUM_SUB:                w_value = in_rs_value1 - in_rs_value2;
            OPENUM_AND, OPENUM_ANDI:   w_value = in_rs_value1 & w_op2;
            OPENUM_OR,  OPENUM_ORI:    w_value = in_rs_value1 | w_op2;
            OPENUM_XOR, OPENUM_XORI:   w_value = in_rs_value1 ^ w_op2;
            OPENUM_SLT, OPENUM_SLTI:
                w_value = {{(DATA_W-1){1'b0}}, ($signed(in_rs_value1) < $signed(w_op2))};
            OPENUM_SLTU, OPENUM_SLTIU:
                w_value = {{(DATA_W-1){1'b0}}, (in_rs_value1 < w_op2)};
            OPENUM_SLL, OPENUM_SLLI:   w_value = in_rs_value1 << w_shamt;
            OPENUM_SRL, OPENUM_SRLI:   w_value = in_rs_value1 >> w_shamt;
            OPENUM_SRA, OPENUM_SRAI:   w_value = $signed(in_rs_value1) >>> w_shamt;
            OPENUM_LUI:                w_value = in_rs_imm;
            OPENUM_AUIPC:              w_value = w_pc_plus_imm;
            OPENUM_JAL: begin
                w_value  = w_pc_plus4;
                w_jump   = TRUE;
                w_target = w_pc_plus_imm;
            end
            OPENUM_JALR: begin
                w_value  = w_pc_plus4;
                w_jump   = TRUE;
                w_target = {w_jalr_sum[DATA_W-1:1], 1'b0};
            end
            OPENUM_BEQ, OPENUM_BNE, OPENUM_BLT, OPENUM_BGE,
            OPENUM_BLTU, OPENUM_BGEU: begin
                w_jump   = w_taken;
                w_target = w_taken ? w_pc_plus_imm : w_pc_plus4;
            end
            default:                   w_known = FALSE;
        endcase
    end

    assign w_issue = w_known && (in_rs_rob_pos != ROB_W'(ZERO_ROB)) && !in_rob_xbp;

    // On idle or flush only the tag and jump flag are cleared; value/target keep their last contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cdb_pos    <= ROB_W'(ZERO_ROB);
            r_cdb_value  <= '0;
            r_cdb_jump   <= FALSE;
            r_cdb_target <= '0;
        end else if (rdy) begin
            if (w_issue) begin
                r_cdb_pos    <= in_rs_rob_pos;
                r_cdb_value  <= w_value;
                r_cdb_jump   <= w_jump;
                r_cdb_target <= w_target;
            end else begin
                r_cdb_pos    <= ROB_W'(ZERO_ROB);
                r_cdb_jump   <= FALSE;
            end
        end
    end

    assign out_cdb_pos    = r_cdb_pos;
    assign out_cdb_value  = r_cdb_value;
    assign out_cdb_jump   = r_cdb_jump;
    assign out_cdb_target = r_cdb_target;

endmodule

// File: tb/tb_alu_exec.sv
// Bench for alu_exec: directed cases plus randomized ops against a behavioural CDB model.
module tb_alu_exec;
    import alu_exec_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [5:0]  in_rs_op;
    logic [31:0] in_rs_value1;
    logic [31:0] in_rs_value2;
    logic [31:0] in_rs_imm;
    logic [3:0]  in_rs_rob_pos;
    logic [31:0] in_rs_pc;
    logic        in_rob_xbp;
    logic [3:0]  out_cdb_pos;
    logic [31:0] out_cdb_value;
    logic        out_cdb_jump;
    logic [31:0] out_cdb_target;

    always #5 clk = ~clk;

    alu_exec dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .in_rs_op       (in_rs_op),
        .in_rs_value1   (in_rs_value1),
        .in_rs_value2   (in_rs_value2),
        .in_rs_imm      (in_rs_imm),
        .in_rs_rob_pos  (in_rs_rob_pos),
        .in_rs_pc       (in_rs_pc),
        .in_rob_xbp     (in_rob_xbp),
        .out_cdb_pos    (out_cdb_pos),
        .out_cdb_value  (out_cdb_value),
        .out_cdb_jump   (out_cdb_jump),
        .out_cdb_target (out_cdb_target)
    );

    int n_chk = 0;
    int n_err = 0;

    // expected bus contents
    logic [3:0]  m_pos;
    logic [31:0] m_value;
    logic        m_jump;
    logic [31:0] m_target;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic [5:0] op, input logic [31:0] v1, input logic [31:0] v2,
                              input logic [31:0] imm, input logic [3:0] pos, input logic [31:0] pc,
                              input logic rdy_v, input logic xbp_v, input logic rst_v);
        bit          ok;
        bit          jmp;
        bit          tk;
        logic [31:0] val;
        logic [31:0] tgt;
        logic [31:0] jt;
        if (rst_v) begin
            m_pos = 0; m_value = 0; m_jump = 0; m_target = 0;
            return;
        end
        if (!rdy_v) return;
        ok = 1; jmp = 0; tk = 0; val = 0; tgt = pc + 32'd4;
        case (op)
            OPENUM_ADD:   val = v1 + v2;
            OPENUM_ADDI:  val = v1 + imm;
            OPENUM_SUB:   val = v1 - v2;
            OPENUM_AND:   val = v1 & v2;
            OPENUM_ANDI:  val = v1 & imm;
            OPENUM_OR:    val = v1 | v2;
            OPENUM_ORI:   val = v1 | imm;
            OPENUM_XOR:   val = v1 ^ v2;
            OPENUM_XORI:  val = v1 ^ imm;
            OPENUM_SLT:   val = (int'(v1) < int'(v2)) ? 32'd1 : 32'd0;
            OPENUM_SLTI:  val = (int'(v1) < int'(imm)) ? 32'd1 : 32'd0;
            OPENUM_SLTU:  val = (v1 < v2) ? 32'd1 : 32'd0;
            OPENUM_SLTIU: val = (v1 < imm) ? 32'd1 : 32'd0;
            OPENUM_SLL:   val = v1 << v2[4:0];
            OPENUM_SLLI:  val = v1 << imm[4:0];
            OPENUM_SRL:   val = v1 >> v2[4:0];
            OPENUM_SRLI:  val = v1 >> imm[4:0];
            OPENUM_SRA:   val = int'(v1) >>> v2[4:0];
            OPENUM_SRAI:  val = int'(v1) >>> imm[4:0];
            OPENUM_LUI:   val = imm;
            OPENUM_AUIPC: val = pc + imm;
            OPENUM_JAL:   begin val = pc + 32'd4; jmp = 1; tgt = pc + imm; end
            OPENUM_JALR:  begin
                jt  = v1 + imm;
                val = pc + 32'd4; jmp = 1; tgt = jt & 32'hFFFF_FFFE;
            end
            OPENUM_BEQ, OPENUM_BNE, OPENUM_BLT, OPENUM_BGE, OPENUM_BLTU, OPENUM_BGEU: begin
                case (op)
                    OPENUM_BEQ:  tk = (v1 == v2);
                    OPENUM_BNE:  tk = (v1 != v2);
                    OPENUM_BLT:  tk = (int'(v1) < int'(v2));
                    OPENUM_BGE:  tk = (int'(v1) >= int'(v2));
                    OPENUM_BLTU: tk = (v1 < v2);
                    default:     tk = (v1 >= v2);
                endcase
                val = 0; jmp = tk;
                tgt = tk ? pc + imm : pc + 32'd4;
            end
            default: ok = 0;
        endcase
        if (xbp_v || !ok || pos == 4'd0) begin
            m_pos = 0; m_jump = 0;
        end else begin
            m_pos = pos; m_value = val; m_jump = jmp; m_target = tgt;
        end
    endtask

    task automatic step(input string tag, input logic [5:0] op, input logic [31:0] v1,
                        input logic [31:0] v2, input logic [31:0] imm, input logic [3:0] pos,
                        input logic [31:0] pc, input logic rdy_v, input logic xbp_v,
                        input logic rst_v);
        in_rs_op = op; in_rs_value1 = v1; in_rs_value2 = v2; in_rs_imm = imm;
        in_rs_rob_pos = pos; in_rs_pc = pc; rdy = rdy_v; in_rob_xbp = xbp_v; rst = rst_v;
        model_step(op, v1, v2, imm, pos, pc, rdy_v, xbp_v, rst_v);
        @(posedge clk);
        #1;
        check_eq($sformatf("%s.pos", tag),    32'(out_cdb_pos),  32'(m_pos));
        check_eq($sformatf("%s.value", tag),  out_cdb_value,     m_value);
        check_eq($sformatf("%s.jump", tag),   32'(out_cdb_jump), 32'(m_jump));
        check_eq($sformatf("%s.target", tag), out_cdb_target,    m_target);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] corners [5];
        corners[0] = 32'h0; corners[1] = 32'h1; corners[2] = 32'h7FFF_FFFF;
        corners[3] = 32'h8000_0000; corners[4] = 32'hFFFF_FFFF;
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    logic [5:0] op_pool [42];

    initial begin
        for (int i = 0; i < 38; i++) op_pool[i] = 6'(i);
        op_pool[38] = 6'd50;
        op_pool[39] = 6'd63;
        op_pool[40] = OPENUM_ADD;
        op_pool[41] = OPENUM_BEQ;

        m_pos = 0; m_value = 0; m_jump = 0; m_target = 0;

        step("reset", OPENUM_ADD, 32'd5, 32'd6, 32'd0, 4'd3, 32'h10, 1'b1, 1'b0, 1'b1);
        step("reset2", OPENUM_NOP, 32'd0, 32'd0, 32'd0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b1);
        check_eq("reset_pos_const", 32'(out_cdb_pos), 32'd0);

        step("add_ovf", OPENUM_ADD, 32'h7FFF_FFFF, 32'd1, 32'd0, 4'd3, 32'h40, 1'b1, 1'b0, 1'b0);
        check_eq("add_ovf_const", out_cdb_value, 32'h8000_0000);
        step("srai", OPENUM_SRAI, 32'h8000_0000, 32'd0, 32'h41F, 4'd5, 32'h50, 1'b1, 1'b0, 1'b0);
        check_eq("srai_const", out_cdb_value, 32'hFFFF_FFFF);
        step("srli", OPENUM_SRLI, 32'h8000_0000, 32'd0, 32'h41F, 4'd5, 32'h54, 1'b1, 1'b0, 1'b0);
        check_eq("srli_const", out_cdb_value, 32'h1);
        step("blt", OPENUM_BLT, 32'hFFFF_FFFF, 32'd1, 32'h20, 4'd7, 32'h100, 1'b1, 1'b0, 1'b0);
        check_eq("blt_target_const", out_cdb_target, 32'h120);
        step("bltu", OPENUM_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h20, 4'd7, 32'h100, 1'b1, 1'b0, 1'b0);
        check_eq("bltu_target_const", out_cdb_target, 32'h104);
        step("jalr", OPENUM_JALR, 32'h1003, 32'd0, 32'd4, 4'd2, 32'h200, 1'b1, 1'b0, 1'b0);
        check_eq("jalr_target_const", out_cdb_target, 32'h1006);
        step("pc_wrap", OPENUM_JAL, 32'd0, 32'd0, 32'h10, 4'd6, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);

        step("b2b1", OPENUM_ADD, 32'd1, 32'd1, 32'd0, 4'd1, 32'h300, 1'b1, 1'b0, 1'b0);
        step("b2b2", OPENUM_SUB, 32'd9, 32'd4, 32'd0, 4'd2, 32'h304, 1'b1, 1'b0, 1'b0);
        step("b2b3", OPENUM_XOR, 32'hF0, 32'hFF, 32'd0, 4'd3, 32'h308, 1'b1, 1'b0, 1'b0);
        step("b2b_nop", OPENUM_NOP, 32'd0, 32'd0, 32'd0, 4'd4, 32'h30C, 1'b1, 1'b0, 1'b0);
        check_eq("b2b_nop_const", 32'(out_cdb_pos), 32'd0);

        step("stall1", OPENUM_ADD, 32'd1, 32'd1, 32'd0, 4'd1, 32'h300, 1'b1, 1'b0, 1'b0);
        step("stall2", OPENUM_SUB, 32'd9, 32'd4, 32'd0, 4'd2, 32'h304, 1'b0, 1'b0, 1'b0);
        check_eq("stall_hold_const", 32'(out_cdb_pos), 32'd1);
        step("stall3", OPENUM_XOR, 32'hF0, 32'hFF, 32'd0, 4'd3, 32'h308, 1'b1, 1'b0, 1'b0);
        step("stall_nop", OPENUM_NOP, 32'd0, 32'd0, 32'd0, 4'd0, 32'h30C, 1'b1, 1'b0, 1'b0);

        step("pre_flush", OPENUM_JAL, 32'd0, 32'd0, 32'h40, 4'd9, 32'h400, 1'b1, 1'b0, 1'b0);
        step("flush", OPENUM_JAL, 32'd0, 32'd0, 32'h40, 4'd4, 32'h500, 1'b1, 1'b1, 1'b0);
        check_eq("flush_jump_const", 32'(out_cdb_jump), 32'd0);
        step("unknown_op", 6'd50, 32'd1, 32'd2, 32'd3, 4'd4, 32'h600, 1'b1, 1'b0, 1'b0);
        step("load_op", OPENUM_LW, 32'd1, 32'd2, 32'd3, 4'd4, 32'h600, 1'b1, 1'b0, 1'b0);
        step("zero_pos", OPENUM_ADD, 32'd1, 32'd2, 32'd3, 4'd0, 32'h600, 1'b1, 1'b0, 1'b0);
        step("rst_op", OPENUM_JAL, 32'd1, 32'd2, 32'h80, 4'd4, 32'h700, 1'b1, 1'b0, 1'b1);
        check_eq("rst_target_const", out_cdb_target, 32'd0);

        for (int i = 0; i < 600; i++) begin
            step("rand", op_pool[$urandom_range(0, 41)], rand_word(), rand_word(), rand_word(),
                 4'($urandom_range(0, 15)), rand_word(),
                 ($urandom_range(0, 99) < 85), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 63) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
